// File: rtl/sum_of_squares_3bit_if.sv
// Stream bundle for the sum-of-squares accumulator: square samples in, frame sums out.
// The accumulator connects through the slave modport, its driver through master.
interface sum_of_squares_3bit_if #(
  parameter int ACC_W = 9
);
  logic             sq_valid;
  logic             sq_ready;
  logic [5:0]       sq_data;
  logic             sum_valid;
  logic             sum_ready;
  logic [ACC_W-1:0] sum_data;
  logic             sum_err;

  modport master (
    output sq_valid, sq_data, sum_ready,
    input  sq_ready, sum_valid, sum_data, sum_err
  );

  modport slave (
    input  sq_valid, sq_data, sum_ready,
    output sq_ready, sum_valid, sum_data, sum_err
  );
endinterface

// File: rtl/sum_of_squares_3bit.sv
// Frame accumulator behind the 3-bit squarer: sums N square values per frame and
// holds the sum, plus a sticky "not a perfect square" flag, until it is taken.
module sum_of_squares_3bit #(
  parameter int N     = 8,
  parameter int ACC_W = 6 + $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sum_of_squares_3bit_if.slave bus
);

  localparam int CNT_W = $clog2(N);

  typedef enum logic {
    ACC  = 1'b0,
    DONE = 1'b1
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic               err;
  logic               sum_valid;
  logic [ACC_W-1:0]   sum_data;
  logic               sum_err;
  logic               sq_ready;

  logic               accept;
  logic               last;
  logic               bad;
  logic               take;
  logic [ACC_W-1:0]   sq_ext;

  assign accept = bus.sq_valid & sq_ready;
  assign take   = sum_valid & bus.sum_ready;
  assign last   = (cnt == CNT_W'(N - 1));
  assign sq_ext = ACC_W'(bus.sq_data);

  // Only the eight squares of 0..7 are legal; anything else still gets summed.
  always_comb begin
    bad = 1'b1;
    case (bus.sq_data)
      6'd0, 6'd1, 6'd4, 6'd9, 6'd16, 6'd25, 6'd36, 6'd49: bad = 1'b0;
      default:                                             bad = 1'b1;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; reset here is synchronous, so it lives inside the clocked branch.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ACC;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACC:     if (accept && last) state_nxt = DONE;
      DONE:    if (take)           state_nxt = ACC;
      default:                     state_nxt = ACC;
    endcase
  end

  // Input readiness depends on state alone, never on sq_valid.
  always_comb begin
    sq_ready = 1'b0;
    case (state)
      ACC:     sq_ready = 1'b1;
      DONE:    sq_ready = 1'b0;
      default: sq_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc       <= '0;
      cnt       <= '0;
      err       <= 1'b0;
      sum_valid <= 1'b0;
      sum_data  <= '0;
      sum_err   <= 1'b0;
    end else begin
      if (accept) begin
        if (last) begin
          sum_data  <= acc + sq_ext;
          sum_err   <= err | bad;
          sum_valid <= 1'b1;
          acc       <= '0;
          cnt       <= '0;
          err       <= 1'b0;
        end else begin
          acc <= acc + sq_ext;
          cnt <= cnt + 1'b1;
          err <= err | bad;
        end
      end else if (take) begin
        // Result payload is left in place after the handshake.
        sum_valid <= 1'b0;
      end
    end
  end

  assign bus.sq_ready  = sq_ready;
  assign bus.sum_valid = sum_valid;
  assign bus.sum_data  = sum_data;
  assign bus.sum_err   = sum_err;

endmodule

// File: tb/tb_sum_of_squares_3bit.sv
// Directed bench for sum_of_squares_3bit: an N=8 instance for the main frames and
// an N=2 instance for the small-frame case, both on one clock and reset.
module tb_sum_of_squares_3bit;

  logic clk = 1'b0;
  logic rst_n;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sum_of_squares_3bit_if #(.ACC_W(9)) bus8 ();
  sum_of_squares_3bit_if #(.ACC_W(7)) bus2 ();

  sum_of_squares_3bit #(.N(8), .ACC_W(9)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8.slave)
  );

  sum_of_squares_3bit #(.N(2), .ACC_W(7)) u_dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed8(input logic [5:0] v);
    bus8.sq_valid = 1'b1;
    bus8.sq_data  = v;
    tick();
    bus8.sq_valid = 1'b0;
  endtask

  task automatic run_frame8(input logic [5:0] v [8], input int exp_sum,
                            input logic exp_err, input string tag);
    for (int i = 0; i < 8; i++) begin
      feed8(v[i]);
      check($sformatf("%s_valid%0d", tag, i), 32'(bus8.sum_valid), 32'(i == 7));
    end
    check({tag, "_data"},  32'(bus8.sum_data), 32'(exp_sum));
    check({tag, "_err"},   32'(bus8.sum_err),  32'(exp_err));
    check({tag, "_sqrdy"}, 32'(bus8.sq_ready), 32'd0);
  endtask

  logic [5:0] f_basic [8];
  logic [5:0] f_max   [8];
  logic [5:0] f_ones  [8];
  logic [5:0] f_fours [8];

  initial begin
    f_basic = '{6'd0, 6'd1, 6'd4, 6'd9, 6'd16, 6'd25, 6'd36, 6'd49};
    f_max   = '{6'd49, 6'd49, 6'd49, 6'd49, 6'd49, 6'd49, 6'd49, 6'd49};
    f_ones  = '{6'd1, 6'd1, 6'd1, 6'd1, 6'd1, 6'd1, 6'd1, 6'd1};
    f_fours = '{6'd4, 6'd4, 6'd4, 6'd4, 6'd4, 6'd4, 6'd4, 6'd4};

    bus8.sq_valid = 1'b0; bus8.sq_data = '0; bus8.sum_ready = 1'b0;
    bus2.sq_valid = 1'b0; bus2.sq_data = '0; bus2.sum_ready = 1'b1;

    // Reset with noise on the inputs.
    rst_n = 1'b0;
    repeat (3) begin
      bus8.sq_valid = 1'($urandom);
      bus8.sq_data  = 6'($urandom);
      bus2.sq_valid = 1'($urandom);
      bus2.sq_data  = 6'($urandom);
      tick();
    end
    rst_n = 1'b1;
    bus8.sq_valid = 1'b0;
    bus2.sq_valid = 1'b0;
    check("rst_sum_valid", 32'(bus8.sum_valid), 32'd0);
    check("rst_sum_data",  32'(bus8.sum_data),  32'd0);
    check("rst_sum_err",   32'(bus8.sum_err),   32'd0);
    check("rst_sq_ready",  32'(bus8.sq_ready),  32'd1);
    check("rst2_sum_valid", 32'(bus2.sum_valid), 32'd0);

    // Basic frame, consumer always ready: result visible for exactly one cycle.
    bus8.sum_ready = 1'b1;
    run_frame8(f_basic, 140, 1'b0, "basic");
    tick();
    check("basic_valid_drop", 32'(bus8.sum_valid), 32'd0);
    check("basic_sqrdy_back", 32'(bus8.sq_ready),  32'd1);
    check("basic_data_kept",  32'(bus8.sum_data),  32'd140);

    // Max frame under back-pressure; offered samples must not be consumed.
    bus8.sum_ready = 1'b0;
    run_frame8(f_max, 392, 1'b0, "max");
    bus8.sq_valid = 1'b1;
    bus8.sq_data  = 6'd1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("bp_valid%0d", i), 32'(bus8.sum_valid), 32'd1);
      check($sformatf("bp_data%0d", i),  32'(bus8.sum_data),  32'd392);
      check($sformatf("bp_sqrdy%0d", i), 32'(bus8.sq_ready),  32'd0);
    end
    bus8.sq_valid  = 1'b0;
    bus8.sum_ready = 1'b1;
    tick();
    check("bp_release_valid", 32'(bus8.sum_valid), 32'd0);
    check("bp_release_sqrdy", 32'(bus8.sq_ready),  32'd1);
    run_frame8(f_ones, 8, 1'b0, "after_bp");
    tick();

    // Bubbles plus an illegal value: 4 + 50 + 9 = 63, flagged.
    feed8(6'd4);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("bub_idle%0d", i), 32'(bus8.sum_valid), 32'd0);
    end
    feed8(6'd50);
    feed8(6'd9);
    for (int i = 0; i < 4; i++) begin
      feed8(6'd0);
      check($sformatf("bub_valid%0d", i), 32'(bus8.sum_valid), 32'd0);
    end
    feed8(6'd0);
    check("bub_sum_valid", 32'(bus8.sum_valid), 32'd1);
    check("bub_sum_data",  32'(bus8.sum_data),  32'd63);
    check("bub_sum_err",   32'(bus8.sum_err),   32'd1);
    tick();
    run_frame8(f_ones, 8, 1'b0, "err_clear");
    tick();

    // Reset mid-frame; an accept offered during reset must lose.
    for (int i = 0; i < 4; i++) feed8(6'd49);
    rst_n = 1'b0;
    bus8.sq_valid = 1'b1;
    bus8.sq_data  = 6'd49;
    tick();
    rst_n = 1'b1;
    bus8.sq_valid = 1'b0;
    check("midrst_sum_valid", 32'(bus8.sum_valid), 32'd0);
    check("midrst_sum_data",  32'(bus8.sum_data),  32'd0);
    check("midrst_sq_ready",  32'(bus8.sq_ready),  32'd1);
    run_frame8(f_fours, 32, 1'b0, "midrst");
    tick();

    // N=2 instance: frame completes on the second accept.
    bus2.sq_valid = 1'b1;
    bus2.sq_data  = 6'd36;
    tick();
    check("n2_valid0", 32'(bus2.sum_valid), 32'd0);
    bus2.sq_data  = 6'd49;
    tick();
    bus2.sq_valid = 1'b0;
    check("n2_valid1", 32'(bus2.sum_valid), 32'd1);
    check("n2_data",   32'(bus2.sum_data),  32'd85);
    check("n2_err",    32'(bus2.sum_err),   32'd0);
    check("n2_sqrdy",  32'(bus2.sq_ready),  32'd0);
    tick();
    check("n2_valid_drop", 32'(bus2.sum_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
